// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing constants for the Common Data Bus arbiter and its consumers.
package cdb_arbiter_pkg;

    localparam int EU_N        = 8;
    localparam int XLEN        = 64;
    localparam int ROB_DEPTH   = 16;
    localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);
    localparam int EU_IDX_LEN  = $clog2(EU_N);

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic [XLEN-1:0]        value;
        logic                   except;
    } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Generic round-robin arbiter: the highest-priority requester is the one at the pointer,
// and the pointer moves just past each winner. Also reused by the issue-queue issue arbiter.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] ptr_nxt_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             found_s;
    logic [IDX_W:0]   cand_s;

    // Scan requesters starting at the pointer, wrapping modulo N, and keep the first hit.
    always_comb begin
        win_idx_s = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(N)) begin
                cand_s = cand_s - (IDX_W+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IDX_W-1:0]]) begin
                found_s   = 1'b1;
                win_idx_s = cand_s[IDX_W-1:0];
            end else begin
                found_s   = found_s;
            end
        end
    end

    // One-hot grant only when enabled, plus the pointer value that follows the winner.
    always_comb begin
        gnt       = '0;
        gnt_idx   = win_idx_s;
        ptr_nxt_s = ptr_r;
        if (en && found_s) begin
            gnt[win_idx_s] = 1'b1;
            if (win_idx_s == IDX_W'(N - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = win_idx_s + IDX_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Priority pointer register; holds whenever nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one finished EU result per cycle round-robin and
// registers it into a single-entry output stage drained by the ROB via valid/ready.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic [EU_N-1:0]     eu_valid_i,
    output logic [EU_N-1:0]     eu_ready_o,
    input  cdb_t [EU_N-1:0]     eu_data_i,
    output logic                cdb_valid_o,
    input  logic                cdb_ready_i,
    output cdb_t                cdb_data_o
);

    logic                  cdb_valid_r;
    cdb_t                  cdb_data_r;
    logic                  cdb_valid_nxt_s;
    cdb_t                  cdb_data_nxt_s;
    logic                  stage_free_s;
    logic                  grant_en_s;
    logic [EU_N-1:0]       gnt_s;
    logic [EU_IDX_LEN-1:0] gnt_idx_s;
    logic                  handshake_s;
    cdb_t                  win_data_s;

    // The stage can accept a new result if empty or being drained this very cycle.
    always_comb begin
        stage_free_s = !cdb_valid_r || cdb_ready_i;
        grant_en_s   = rst_n_i && !flush_i && stage_free_s;
    end

    rr_arbiter #(
        .N     (EU_N),
        .IDX_W (EU_IDX_LEN)
    ) u_rr (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .req     (eu_valid_i),
        .en      (grant_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Result mux and output-stage next state; flush outranks any handshake.
    always_comb begin
        handshake_s     = |gnt_s;
        win_data_s      = eu_data_i[gnt_idx_s];
        cdb_valid_nxt_s = cdb_valid_r;
        cdb_data_nxt_s  = cdb_data_r;
        if (flush_i) begin
            cdb_valid_nxt_s = 1'b0;
        end else if (handshake_s) begin
            cdb_valid_nxt_s = 1'b1;
            cdb_data_nxt_s  = win_data_s;
        end else if (cdb_ready_i) begin
            cdb_valid_nxt_s = 1'b0;
        end else begin
            cdb_valid_nxt_s = cdb_valid_r;
        end
    end

    // Output stage register; data is kept on drain so the bus does not toggle needlessly.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cdb_valid_r <= 1'b0;
            cdb_data_r  <= '0;
        end else begin
            cdb_valid_r <= cdb_valid_nxt_s;
            cdb_data_r  <= cdb_data_nxt_s;
        end
    end

    assign eu_ready_o  = gnt_s;
    assign cdb_valid_o = cdb_valid_r;
    assign cdb_data_o  = cdb_data_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table for the named corner cases, then
// constrained-random traffic checked against a queue-free reference model of the rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [EU_N-1:0]   eu_valid;
    logic [EU_N-1:0]   eu_ready;
    cdb_t [EU_N-1:0]   eu_data;
    logic              cdb_valid;
    logic              cdb_ready;
    cdb_t              cdb_data;

    int errors = 0;
    int checks = 0;

    cdb_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .eu_valid_i  (eu_valid),
        .eu_ready_o  (eu_ready),
        .eu_data_i   (eu_data),
        .cdb_valid_o (cdb_valid),
        .cdb_ready_i (cdb_ready),
        .cdb_data_o  (cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst_n;
        logic            flush;
        logic [EU_N-1:0] valid;
        logic            rdy;
        logic [EU_N-1:0] exp_ready;
        logic            exp_cv;
        logic            chk_rob;
        logic [3:0]      exp_rob;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cdb_t dir_data(input int i);
        cdb_t d;
        d.rob_idx = ROB_IDX_LEN'(i + 3);
        d.value   = 64'hC0DE_0000_0000_0000 | 64'(i);
        d.except  = (i == 6);
        return d;
    endfunction

    function automatic void add(input logic r, input logic f, input logic [7:0] v, input logic rd,
                                input logic [7:0] er, input logic ecv, input logic ck, input int rob);
        vec_t x;
        x.rst_n = r; x.flush = f; x.valid = v; x.rdy = rd;
        x.exp_ready = er; x.exp_cv = ecv; x.chk_rob = ck; x.exp_rob = 4'(rob);
        vecs.push_back(x);
    endfunction

    // reference model state
    int    m_ptr;
    logic  m_cv;
    cdb_t  m_data;
    int    m_win;

    function automatic int model_winner(input logic r, input logic f, input logic [7:0] v, input logic rd);
        if (!r || f || (m_cv && !rd)) return -1;
        for (int k = 0; k < EU_N; k++) begin
            if (v[(m_ptr + k) % EU_N]) return (m_ptr + k) % EU_N;
        end
        return -1;
    endfunction

    initial begin
        logic [EU_N-1:0] exp_rdy;
        rst_n = 1'b0; flush = 1'b0; eu_valid = '1; cdb_ready = 1'b1;
        for (int i = 0; i < EU_N; i++) eu_data[i] = dir_data(i);
        repeat (2) @(posedge clk);

        // directed table
        add(0,0,8'hFF,1, 8'h00,0,0,0);
        add(1,0,8'hFF,1, 8'h01,0,0,0);
        for (int k = 1; k <= 8; k++) add(1,0,8'hFF,1, 8'(1 << (k % 8)),1,1,k+2);
        add(1,0,8'h00,1, 8'h00,1,1,3);
        add(1,0,8'h08,1, 8'h08,0,0,0);
        add(1,0,8'h28,1, 8'h20,1,1,6);
        add(1,0,8'h08,1, 8'h08,1,1,8);
        add(1,0,8'h12,1, 8'h10,1,1,6);
        for (int k = 0; k < 3; k++) add(1,0,8'h02,0, 8'h00,1,1,7);
        add(1,0,8'h02,1, 8'h02,1,1,7);
        add(1,0,8'h00,0, 8'h00,1,1,4);
        add(1,1,8'h04,0, 8'h00,1,1,4);
        add(1,0,8'h04,0, 8'h04,0,0,0);
        add(1,0,8'h40,1, 8'h40,1,1,5);
        add(1,0,8'h80,1, 8'h80,1,1,9);
        add(1,0,8'h81,1, 8'h01,1,1,10);
        add(1,0,8'h00,1, 8'h00,1,1,3);
        add(1,0,8'h00,0, 8'h00,0,1,3);
        add(1,0,8'h02,1, 8'h02,0,0,0);
        add(0,0,8'hFF,1, 8'h00,1,1,4);
        add(1,0,8'h80,1, 8'h80,0,1,0);

        for (int s = 0; s < vecs.size(); s++) begin
            @(negedge clk);
            rst_n = vecs[s].rst_n; flush = vecs[s].flush;
            eu_valid = vecs[s].valid; cdb_ready = vecs[s].rdy;
            #1;
            chk($sformatf("dir%0d eu_ready", s), 128'(eu_ready), 128'(vecs[s].exp_ready));
            chk($sformatf("dir%0d cdb_valid", s), 128'(cdb_valid), 128'(vecs[s].exp_cv));
            if (vecs[s].chk_rob)
                chk($sformatf("dir%0d rob_idx", s), 128'(cdb_data.rob_idx), 128'(vecs[s].exp_rob));
        end

        // randomized traffic against the reference model, starting from a reset
        @(negedge clk);
        rst_n = 1'b0; flush = 1'b0; eu_valid = '0; cdb_ready = 1'b0;
        m_ptr = 0; m_cv = 1'b0; m_data = '0; m_win = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 79) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cdb_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < EU_N; i++) begin
                if (!(eu_valid[i] && m_win != i)) begin
                    eu_valid[i]        = ($urandom_range(0, 2) == 0);
                    eu_data[i].rob_idx = ROB_IDX_LEN'($urandom);
                    eu_data[i].value   = {$urandom, $urandom};
                    eu_data[i].except  = 1'($urandom_range(0, 1));
                end
            end
            #1;
            m_win   = model_winner(rst_n, flush, eu_valid, cdb_ready);
            exp_rdy = (m_win < 0) ? '0 : EU_N'(1) << m_win;
            chk("rnd eu_ready", 128'(eu_ready), 128'(exp_rdy));
            chk("rnd cdb_valid", 128'(cdb_valid), 128'(m_cv));
            if (m_cv) chk("rnd cdb_data", 128'(cdb_data), 128'(m_data));
            if (!rst_n) begin
                m_ptr = 0; m_cv = 1'b0; m_data = '0;
            end else if (flush) begin
                m_cv = 1'b0;
            end else if (m_win >= 0) begin
                m_cv = 1'b1; m_data = eu_data[m_win]; m_ptr = (m_win + 1) % EU_N;
            end else if (cdb_ready) begin
                m_cv = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
